// File: rtl/seven_seg_mux_n.sv
// ============================================================================
// Module   : seven_seg_mux_n
// Brief    : Multiplexed hex driver for 1..8 common-anode 7-segment digits,
//            with per-digit enable/dp/blink, leading-zero blanking and a
//            frame-coherent shadow latch. All outputs registered, active-low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_mux_n #(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_CNT  = 50000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   val,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic [N_DIGITS-1:0]     blink_en,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [7:0]              an,
    output logic                    frame_tick
);

    localparam int CNT_W = (REFRESH_CNT  > 1) ? $clog2(REFRESH_CNT)  : 1;
    localparam int IDX_W = (N_DIGITS     > 1) ? $clog2(N_DIGITS)     : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(REFRESH_CNT - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [FRM_W-1:0] C_FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [FRM_W-1:0]       r_frm;
    logic                   r_blink_phase;
    logic                   r_load_pending;
    logic                   r_wrap_d;
    logic                   r_frame_tick;
    logic [6:0]             r_seg;
    logic                   r_dp;
    logic [7:0]             r_an;

    logic [4*N_DIGITS-1:0]  r_sh_val;
    logic [N_DIGITS-1:0]    r_sh_dp;
    logic [N_DIGITS-1:0]    r_sh_en;
    logic [N_DIGITS-1:0]    r_sh_blink;
    logic                   r_sh_lz;

    logic                   w_cnt_last;
    logic                   w_frame_wrap;
    logic [N_DIGITS:1]      w_zero_from;
    logic [N_DIGITS-1:0]    w_lz_dig;
    logic [3:0]             w_nib;
    logic                   w_dp_req;
    logic                   w_en;
    logic                   w_blk;
    logic                   w_lzb;
    logic [7:0]             w_an_sel;
    logic                   w_visible;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    assign w_cnt_last   = (r_cnt == C_CNT_LAST);
    assign w_frame_wrap = w_cnt_last && (r_idx == C_IDX_LAST);

    // Digit i is a leading zero when it and every more-significant nibble are 0.
    assign w_zero_from[N_DIGITS] = 1'b1;
    assign w_lz_dig[0]           = 1'b0;
    generate
        for (genvar gi = 1; gi < N_DIGITS; gi++) begin : g_lz
            assign w_zero_from[gi] = (r_sh_val[4*gi +: 4] == 4'h0) && w_zero_from[gi+1];
            assign w_lz_dig[gi]    = r_sh_lz && w_zero_from[gi];
        end
    endgenerate

    always_comb begin
        w_nib    = 4'h0;
        w_dp_req = 1'b0;
        w_en     = 1'b0;
        w_blk    = 1'b0;
        w_lzb    = 1'b0;
        w_an_sel = 8'hFF;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_sh_val[4*i +: 4];
                w_dp_req    = r_sh_dp[i];
                w_en        = r_sh_en[i];
                w_blk       = r_sh_blink[i];
                w_lzb       = w_lz_dig[i];
                w_an_sel[i] = 1'b0;
            end
        end
    end

    assign w_visible = w_en && !(w_blk && r_blink_phase) && !w_lzb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_idx          <= '0;
            r_frm          <= '0;
            r_blink_phase  <= 1'b0;
            r_load_pending <= 1'b1;
            r_wrap_d       <= 1'b0;
            r_frame_tick   <= 1'b0;
            r_sh_val       <= '0;
            r_sh_dp        <= '0;
            r_sh_en        <= '0;
            r_sh_blink     <= '0;
            r_sh_lz        <= 1'b0;
            r_seg          <= 7'h7F;
            r_dp           <= 1'b1;
            r_an           <= 8'hFF;
        end else begin
            r_load_pending <= 1'b0;

            if (w_cnt_last) begin
                r_cnt <= '0;
                r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Tick is delayed one cycle so it lines up with the slot-0 output.
            r_wrap_d     <= w_frame_wrap;
            r_frame_tick <= r_wrap_d;

            // Blink state advances on the frame boundary so a frame never changes phase mid-scan.
            if (w_frame_wrap) begin
                if (r_frm == C_FRM_LAST) begin
                    r_frm         <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frm <= r_frm + FRM_W'(1);
                end
            end

            if (w_frame_wrap || r_load_pending) begin
                r_sh_val   <= val;
                r_sh_dp    <= dp_in;
                r_sh_en    <= digit_en;
                r_sh_blink <= blink_en;
                r_sh_lz    <= lz_blank;
            end

            if (w_visible) begin
                r_an  <= w_an_sel;
                r_seg <= hex_glyph(w_nib);
                r_dp  <= ~w_dp_req;
            end else begin
                r_an  <= 8'hFF;
                r_seg <= 7'h7F;
                r_dp  <= 1'b1;
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_mux_n.sv
// ============================================================================
// Module   : tb_seven_seg_mux_n
// Brief    : Self-checking bench for seven_seg_mux_n (4-digit and 8-digit builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_mux_n;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    typedef struct packed {
        logic [15:0]     val;
        logic [3:0]      dpi;
        logic [3:0]      en;
        logic [3:0]      blk;
        logic            lz;
        logic [3:0][7:0] an;
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] val;
    logic [3:0]  dp_in, digit_en, blink_en;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        frame_tick;

    logic [31:0] val8;
    logic [7:0]  dp8_in, en8, blk8;
    logic        lz8;
    logic [6:0]  seg8;
    logic        dp8;
    logic [7:0]  an8;
    logic        ft8;

    vec_t tbl [10];
    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    seven_seg_mux_n #(.N_DIGITS(4), .REFRESH_CNT(4), .BLINK_FRAMES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .val(val), .dp_in(dp_in), .digit_en(digit_en),
        .blink_en(blink_en), .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an),
        .frame_tick(frame_tick)
    );

    seven_seg_mux_n #(.N_DIGITS(8), .REFRESH_CNT(2), .BLINK_FRAMES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .val(val8), .dp_in(dp8_in), .digit_en(en8),
        .blink_en(blk8), .lz_blank(lz8), .seg(seg8), .dp(dp8), .an(an8),
        .frame_tick(ft8)
    );

    task automatic apply(input vec_t v);
        val      = v.val;
        dp_in    = v.dpi;
        digit_en = v.en;
        blink_en = v.blk;
        lz_blank = v.lz;
    endtask

    // Queue one full scan frame (4 slots x 4 cycles) of expected outputs.
    task automatic push_frame(input vec_t v, input bit phase, input bit first_blank);
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                if (v.blk[s] && phase) begin
                    e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
                end else begin
                    e.an = v.an[s]; e.seg = v.seg[s]; e.dp = v.dp[s];
                end
                e.ft = (s == 0 && c == 0);
                if (first_blank && s == 0 && c == 0) begin
                    e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b0;
                end
                sb.push_back(e);
            end
        end
    endtask

    task automatic check_cycles(input int n, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL %s[%0d]: scoreboard empty, got an=%h seg=%h", tag, i, an, seg);
            end else begin
                e = sb.pop_front();
                if ({an, seg, dp, frame_tick} !== e) begin
                    n_bad++;
                    $display("FAIL %s[%0d]: got an=%h seg=%h dp=%b tick=%b, want an=%h seg=%h dp=%b tick=%b",
                             tag, i, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.ft);
                end
            end
        end
    endtask

    task automatic wait_tick(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_tick !== 1'b1 && k < 200);
        n_cmp++;
        if (frame_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: no frame_tick within %0d cycles, got tick=%b want 1", tag, k, frame_tick);
        end
    endtask

    task automatic check_reset(input string tag);
        n_cmp++;
        if ({an, seg, dp, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL %s: got an=%h seg=%h dp=%b tick=%b, want an=ff seg=7f dp=1 tick=0",
                     tag, an, seg, dp, frame_tick);
        end
    endtask

    // Latch a vector: skip the possibly stale frame, then check one whole frame.
    task automatic sync_vec(input vec_t v, input string tag);
        apply(v);
        wait_tick(tag);
        repeat (15) @(negedge clk);
        push_frame(v, 1'b0, 1'b0);
        check_cycles(16, tag);
    endtask

    initial begin
        logic [6:0] g8 [8];
        logic [7:0] one;
        int k;
        g8  = '{7'h0E, 7'h06, 7'h06, 7'h03, 7'h21, 7'h08, 7'h06, 7'h21};
        one = 8'h01;

        //            val       dpi    en     blk    lz    an[3..0]                        seg[3..0]                       dp[3..0]
        tbl[0] = '{16'h1234, 4'h0, 4'hF, 4'h0, 1'b0, {8'hF7,8'hFB,8'hFD,8'hFE}, {7'h79,7'h24,7'h30,7'h19}, 4'hF};
        tbl[1] = '{16'h0050, 4'h0, 4'hF, 4'h0, 1'b1, {8'hFF,8'hFF,8'hFD,8'hFE}, {7'h7F,7'h7F,7'h12,7'h40}, 4'hF};
        tbl[2] = '{16'h0000, 4'h0, 4'hF, 4'h0, 1'b1, {8'hFF,8'hFF,8'hFF,8'hFE}, {7'h7F,7'h7F,7'h7F,7'h40}, 4'hF};
        tbl[3] = '{16'h0050, 4'h5, 4'hF, 4'h0, 1'b0, {8'hF7,8'hFB,8'hFD,8'hFE}, {7'h40,7'h40,7'h12,7'h40}, 4'hA};
        tbl[4] = '{16'hABCD, 4'h0, 4'hA, 4'h0, 1'b0, {8'hF7,8'hFF,8'hFD,8'hFF}, {7'h08,7'h7F,7'h46,7'h7F}, 4'hF};
        tbl[5] = '{16'hEF09, 4'h0, 4'hF, 4'h0, 1'b1, {8'hF7,8'hFB,8'hFD,8'hFE}, {7'h06,7'h0E,7'h40,7'h10}, 4'hF};
        tbl[6] = '{16'h0021, 4'h1, 4'h3, 4'h2, 1'b0, {8'hFF,8'hFF,8'hFD,8'hFE}, {7'h7F,7'h7F,7'h24,7'h79}, 4'hE};
        tbl[7] = '{16'h1111, 4'h0, 4'hF, 4'h0, 1'b0, {8'hF7,8'hFB,8'hFD,8'hFE}, {7'h79,7'h79,7'h79,7'h79}, 4'hF};
        tbl[8] = '{16'h2222, 4'h0, 4'hF, 4'h0, 1'b0, {8'hF7,8'hFB,8'hFD,8'hFE}, {7'h24,7'h24,7'h24,7'h24}, 4'hF};
        tbl[9] = '{16'h5678, 4'h0, 4'hF, 4'h0, 1'b0, {8'hF7,8'hFB,8'hFD,8'hFE}, {7'h12,7'h02,7'h78,7'h00}, 4'hF};

        rst_n  = 1'b0;
        apply(tbl[6]);
        val8   = 32'hDEADBEEF;
        dp8_in = 8'h00;
        en8    = 8'hFF;
        blk8   = 8'h00;
        lz8    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");

        // Blink + dp from a known reset phase: frames 0,1 lit, 2,3 dark, 4,5 lit.
        rst_n = 1'b1;
        for (int f = 0; f < 6; f++) push_frame(tbl[6], ((f / 2) % 2) == 1, f == 0);
        check_cycles(96, "blink");

        for (int i = 0; i < 6; i++) sync_vec(tbl[i], $sformatf("vec%0d", i));

        // Tear-free: value changes while slot 2 is showing.
        apply(tbl[7]);
        wait_tick("tear_sync");
        repeat (15) @(negedge clk);
        push_frame(tbl[7], 1'b0, 1'b0);
        push_frame(tbl[8], 1'b0, 1'b0);
        check_cycles(8, "tear");
        val = 16'h2222;
        check_cycles(24, "tear");

        // Reset asserted for one edge while slot 3 is active.
        push_frame(tbl[8], 1'b0, 1'b0);
        check_cycles(12, "pre_rst");
        sb.delete();
        rst_n = 1'b0;
        apply(tbl[9]);
        @(negedge clk);
        check_reset("rst_mid");
        rst_n = 1'b1;
        push_frame(tbl[9], 1'b0, 1'b1);
        push_frame(tbl[9], 1'b0, 1'b0);
        check_cycles(32, "post_rst");

        // Eight-digit build, two full frames.
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ft8 !== 1'b1 && k < 200);
        n_cmp++;
        if (ft8 !== 1'b1) begin
            n_bad++;
            $display("FAIL n8_sync: no frame_tick within %0d cycles, got tick=%b want 1", k, ft8);
        end
        for (int c = 0; c < 32; c++) begin
            int s;
            logic [7:0] ea;
            if (c != 0) @(negedge clk);
            s  = (c % 16) / 2;
            ea = ~(one << s);
            n_cmp++;
            if ({an8, seg8, dp8, ft8} !== {ea, g8[s], 1'b1, (c % 16) == 0}) begin
                n_bad++;
                $display("FAIL n8[%0d]: got an=%h seg=%h dp=%b tick=%b, want an=%h seg=%h dp=1 tick=%b",
                         c, an8, seg8, dp8, ft8, ea, g8[s], (c % 16) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/seven_seg_mux_n.md
Name: seven_seg_mux_n

Overview:
- Parametrised multiplexed hexadecimal driver for common-anode 7-segment displays with 1 to 8 digits.
- Adds per-digit enable, per-digit decimal points, per-digit blink, optional leading-zero blanking, and a frame-coherent shadow latch so the display never tears.
- Sits between datapath/debug registers and the board `seg`/`dp`/`an` pins.
- All display outputs are registered and active-low.

Parameters:
- N_DIGITS, 8, number of digits scanned (1..8).
- REFRESH_CNT, 50000, clk cycles each digit stays lit (0.5 ms at 100 MHz); must be ≥ 2.
- BLINK_FRAMES, 128, full scan frames per blink half-period; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Synchronous, active-low, single clock domain (clk).
- val  in  4*N_DIGITS  hex value; nibble i drives digit i (nibble 0 = rightmost).
- dp_in  in  N_DIGITS  decimal point request per digit, active-high.
- digit_en  in  N_DIGITS  digit enable, active-high; 0 = digit dark.
- blink_en  in  N_DIGITS  blink request per digit, active-high.
- lz_blank  in  1  1 = blank leading zero digits.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  8  anodes, active-low; bits ≥ N_DIGITS are always 1.
- frame_tick  out  1  one-cycle pulse at the start of each scan frame.

Behaviour:
Reset (rst_n=0 at a clk edge):
- slot counter cnt=0, digit index idx=0, frame counter=0, blink_phase=0 (visible).
- All shadow registers = 0; load_pending=1.
- Outputs: seg=7'h7F, dp=1, an=8'hFF, frame_tick=0.
- Assertion mid-scan returns every register to these values on that edge.

Scan:
- cnt counts 0..REFRESH_CNT-1, then wraps to 0.
- On the wrap edge, idx advances by one; after N_DIGITS-1 it returns to 0.
- With N_DIGITS=1, idx stays at 0.

Shadow latch:
- Captures val, dp_in, digit_en, blink_en and lz_blank on any edge where idx wraps to 0.
- Also captures on the first edge after reset release, while load_pending=1; that edge clears load_pending.
- The display logic uses only shadow values. Input changes mid-frame have no visible effect until the next frame.

Output register:
- seg, dp and an are computed from the current idx and the shadow registers, then registered.
- Latency: the output for slot k appears exactly one cycle after idx becomes k. an and seg always change on the same edge, so a slot never shows a mismatched anode/segment pair.

Visibility of digit i (all conditions required):
- shadow digit_en[i] = 1.
- NOT (blink_en[i] AND blink_phase = 1).
- NOT leading-zero, where leading-zero means: lz_blank = 1, i ≠ 0, and shadow nibbles i..N_DIGITS-1 are all 0. Digit 0 is never leading-zero blanked.

Visible digit:
- an[i]=0, all other an bits 1.
- seg = standard hex glyph: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- dp = ~dp_in[i].

Blanked digit:
- an=8'hFF, seg=7'h7F, dp=1.

frame_tick:
- Registered pulse, high for exactly one cycle, in the cycle after idx wraps to 0. Aligned with slot 0 output.

Blink:
- The frame counter increments on each frame_tick.
- At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- blink_phase affects only digits whose shadow blink_en bit is set.

Test Plan (N_DIGITS=4, REFRESH_CNT=4, BLINK_FRAMES=2 unless noted):
- Basic scan: reset, then val=16'h1234, digit_en=4'hF, other inputs 0 → repeating an pattern FE, FD, FB, F7, each held 4 cycles. seg per slot: 19, 30, 24, 79. dp=1. frame_tick once every 16 cycles.
- Leading-zero blanking: val=16'h0050, lz_blank=1 → digits 3 and 2 dark (an=FF, seg=7F). Digit 1 shows 12, digit 0 shows 40. Then val=0 → only digit 0 shows 40.
- Blink and decimal point: blink_en=4'b0010, dp_in=4'b0001 → digit 1 lit for 2 frames, dark for 2 frames, repeating. Digit 0 always lit with dp=0.
- Tear-free update: change val from 16'h1111 to 16'h2222 while idx=2 → slots 2 and 3 of the current frame still show 79. The next frame shows 24 on all digits.
- Reset mid-scan: assert rst_n=0 for 1 cycle while idx=3 → next edge an=FF, seg=7F, frame_tick=0. After release, the scan restarts at slot 0 with freshly latched inputs.
- N_DIGITS=8, REFRESH_CNT=2, val=32'hDEADBEEF → an cycles through FE..7F. seg sequence per slot: 0E, 06, 06, 03, 21, 08, 06, 21. frame_tick every 16 cycles.
